// File: rtl/pim_matmul_engine.sv
// ---------------------------------------------------------------------------
// pim_matmul_engine
//   Sequential N x N unsigned matrix multiplier, C = A x B, one
//   multiply-accumulate per clock. Operands are latched when start is
//   accepted. The loop order is i (row), then j (column), then k (dot-product
//   index). Each finished dot product is written into the registered result
//   array. result_ready pulses for one cycle in DONE.
//
//   Optional build macro:
//     PIM_MATMUL_SATURATE_EN - when defined, each result element saturates to
//                              2**WIDTH-1. When undefined (the default), each
//                              element wraps modulo 2**WIDTH.
//
//   Ports:
//     clk           system clock, rising edge active
//     rst           asynchronous active-high reset
//     start         one-cycle request; sampled only in IDLE
//     matrix_A      left operand, element [i*N+k] at bits [(i*N+k)*WIDTH +: WIDTH]
//     matrix_B      right operand, element [k*N+j] at bits [(k*N+j)*WIDTH +: WIDTH]
//     result        product, element [i*N+j], registered
//     result_ready  one-cycle pulse; all result elements valid
//     busy          high from the cycle after acceptance through DONE
// ---------------------------------------------------------------------------
module pim_matmul_engine #(
  parameter int WIDTH = 32,
  parameter int MSIZE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [MSIZE*MSIZE*WIDTH-1:0]   matrix_A,
  input  logic [MSIZE*MSIZE*WIDTH-1:0]   matrix_B,
  output logic [MSIZE*MSIZE*WIDTH-1:0]   result,
  output logic                           result_ready,
  output logic                           busy
);

  localparam int CW    = (MSIZE > 1) ? $clog2(MSIZE) : 1;
  localparam int ACC_W = 2 * WIDTH + $clog2(MSIZE);
  localparam int MAT_W = MSIZE * MSIZE * WIDTH;
  localparam logic [CW-1:0] IDX_LAST = CW'(MSIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [CW-1:0]      i_r, j_r, k_r;
  logic [ACC_W-1:0]   acc_r;
  logic [MAT_W-1:0]   a_r, b_r;
  logic [MAT_W-1:0]   result_r;
  logic               busy_r, ready_r;

  logic               accept_s, last_mac_s;
  int                 a_idx_s, b_idx_s, c_idx_s;
  logic [WIDTH-1:0]   a_el_s, b_el_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [ACC_W-1:0]   acc_base_s, sum_s;
  logic [WIDTH-1:0]   res_el_s;

`ifdef PIM_MATMUL_SATURATE_EN
  // Clamp a full-width dot product to the largest WIDTH-bit value.
  function automatic logic [WIDTH-1:0] sat_reduce(input logic [ACC_W-1:0] s);
    logic [WIDTH-1:0] r;
    if (|s[ACC_W-1:WIDTH]) begin
      r = {WIDTH{1'b1}};
    end else begin
      r = s[WIDTH-1:0];
    end
    return r;
  endfunction

  assign res_el_s = sat_reduce(sum_s);
`else
  // Wrap mode keeps only the low WIDTH bits; the upper bits are dropped.
  logic unused_sum_hi_s;
  assign unused_sum_hi_s = ^sum_s[ACC_W-1:WIDTH];
  assign res_el_s        = sum_s[WIDTH-1:0];
`endif

  assign accept_s   = (state_r == IDLE) && start;
  assign last_mac_s = (i_r == IDX_LAST) && (j_r == IDX_LAST) && (k_r == IDX_LAST);

  // Operand selection and the multiply-accumulate datapath for the current (i,j,k).
  always_comb begin
    a_idx_s    = int'(i_r) * MSIZE + int'(k_r);
    b_idx_s    = int'(k_r) * MSIZE + int'(j_r);
    c_idx_s    = int'(i_r) * MSIZE + int'(j_r);
    a_el_s     = a_r[a_idx_s*WIDTH +: WIDTH];
    b_el_s     = b_r[b_idx_s*WIDTH +: WIDTH];
    prod_s     = {{WIDTH{1'b0}}, a_el_s} * {{WIDTH{1'b0}}, b_el_s};
    // The accumulator restarts at k=0 of every (i,j) by ignoring its old value.
    if (k_r == {CW{1'b0}}) begin
      acc_base_s = {ACC_W{1'b0}};
    end else begin
      acc_base_s = acc_r;
    end
    sum_s = acc_base_s + {{(ACC_W-2*WIDTH){1'b0}}, prod_s};
  end

  // Next-state logic for IDLE -> MAC -> DONE -> IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = MAC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MAC: begin
        if (last_mac_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = MAC;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      ready_r <= (state_nx_s == DONE);
    end
  end

  // Loop counters and accumulator. k is the innermost index and j the middle one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_r   <= {CW{1'b0}};
      j_r   <= {CW{1'b0}};
      k_r   <= {CW{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      i_r   <= {CW{1'b0}};
      j_r   <= {CW{1'b0}};
      k_r   <= {CW{1'b0}};
      acc_r <= {ACC_W{1'b0}};
    end else if (state_r == MAC) begin
      acc_r <= sum_s;
      if (k_r == IDX_LAST) begin
        k_r <= {CW{1'b0}};
        if (j_r == IDX_LAST) begin
          j_r <= {CW{1'b0}};
          if (i_r == IDX_LAST) begin
            i_r <= {CW{1'b0}};
          end else begin
            i_r <= i_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          j_r <= j_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        k_r <= k_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Result array. Each element is written once, when its dot product finishes at k=N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= {MAT_W{1'b0}};
    end else if ((state_r == MAC) && (k_r == IDX_LAST)) begin
      result_r[c_idx_s*WIDTH +: WIDTH] <= res_el_s;
    end
  end

  // Operand capture on the accepting edge. These registers have no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      a_r <= matrix_A;
      b_r <= matrix_B;
    end
  end

  assign result       = result_r;
  assign result_ready = ready_r;
  assign busy         = busy_r;

endmodule
